// File: rtl/tfix2float_if.sv
// AXI-stream style valid/ready channel carrying one W-bit word.
interface tfix2float_if #(
  parameter int unsigned W = 16
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/tfix2float.sv
// Signed fixed-point to binary float converter, round-to-nearest-even,
// one normalisation shift per cycle, one conversion in flight.
module tfix2float #(
  parameter int unsigned EXP = 5,
  parameter int unsigned FRA = 10,
  parameter int unsigned INT = 8,
  parameter int unsigned DEC = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  tfix2float_if.slave  s_axis,
  tfix2float_if.master m_axis
);

  localparam int unsigned W       = INT + DEC;
  localparam int unsigned OW      = EXP + FRA + 1;
  localparam int unsigned BIAS    = 2 ** (EXP - 1) - 1;
  localparam int unsigned EXP_MAX = 2 ** EXP - 1;
  localparam int unsigned EW      = EXP + $clog2(W) + 2;
  localparam int unsigned PW      = W + FRA + 2;

  // Fractional bits must stay below the smallest normal exponent.
  if (DEC > BIAS - 1) begin : g_param_check
    $error("tfix2float: DEC must not exceed BIAS-1");
  end

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    NORM,
    ROUND,
    PACK,
    OUT
  } state_t;

  state_t                state_q;
  logic [W-1:0]          data_q;
  logic [W-1:0]          mag_q;
  logic signed [EW-1:0]  exp_q;
  logic                  sign_q;
  logic                  zero_q;
  logic [FRA-1:0]        frac_q;
  logic                  s_rdy_q;
  logic                  m_vld_q;
  logic [OW-1:0]         m_data_q;

  // Rounding operands: magnitude padded on the right so that m, guard and
  // sticky are always well defined regardless of W versus FRA.
  logic [PW-1:0]         padded_c;
  logic [FRA:0]          m_c;
  logic [FRA:0]          m_inc_c;
  logic                  g_c;
  logic                  s_c;
  logic                  round_up_c;
  logic signed [EW-1:0]  biased_c;

  assign padded_c   = {mag_q, {(FRA + 2){1'b0}}};
  assign m_c        = padded_c[PW-1 -: FRA+1];
  assign g_c        = padded_c[W];
  assign s_c        = |padded_c[W-1:0];
  assign round_up_c = g_c & (s_c | m_c[0]);
  assign m_inc_c    = m_c + (FRA + 1)'(1);
  assign biased_c   = exp_q + $signed(EW'(BIAS));

  assign s_axis.tready = s_rdy_q;
  assign m_axis.tvalid = m_vld_q;
  assign m_axis.tdata  = m_data_q;

  // Conversion state machine with registered handshake outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      data_q   <= '0;
      mag_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      zero_q   <= 1'b0;
      frac_q   <= '0;
      s_rdy_q  <= 1'b0;
      m_vld_q  <= 1'b0;
      m_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_axis.tvalid && s_rdy_q) begin
            data_q  <= s_axis.tdata;
            s_rdy_q <= 1'b0;
            state_q <= ABS;
          end else begin
            s_rdy_q <= 1'b1;
          end
        end
        ABS: begin
          sign_q  <= data_q[W-1];
          mag_q   <= data_q[W-1] ? (~data_q + W'(1)) : data_q;
          exp_q   <= $signed(EW'(W - 1 - DEC));
          zero_q  <= (data_q == '0);
          state_q <= (data_q == '0) ? PACK : NORM;
        end
        NORM: begin
          if (!mag_q[W-1]) begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - $signed(EW'(1));
          end else begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          if (round_up_c && (&m_c)) begin
            frac_q <= '0;
            exp_q  <= exp_q + $signed(EW'(1));
          end else if (round_up_c) begin
            frac_q <= m_inc_c[FRA-1:0];
          end else begin
            frac_q <= m_c[FRA-1:0];
          end
          state_q <= PACK;
        end
        PACK: begin
          if (zero_q) begin
            m_data_q <= '0;
          end else if (biased_c >= $signed(EW'(EXP_MAX))) begin
            m_data_q <= {sign_q, {EXP{1'b1}}, {FRA{1'b0}}};
          end else begin
            m_data_q <= {sign_q, biased_c[EXP-1:0], frac_q};
          end
          m_vld_q <= 1'b1;
          state_q <= OUT;
        end
        OUT: begin
          if (m_axis.tready) begin
            m_vld_q <= 1'b0;
            s_rdy_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tfix2float.sv
// Scoreboard bench for tfix2float: directed vectors, backpressure, reset
// abort and a randomized regression against an arithmetic reference model.
module tb_tfix2float;

  localparam int unsigned EXP = 5;
  localparam int unsigned FRA = 10;
  localparam int unsigned INT = 8;
  localparam int unsigned DEC = 8;
  localparam int unsigned W   = INT + DEC;
  localparam int unsigned OW  = EXP + FRA + 1;
  localparam int          BIAS = 2 ** (EXP - 1) - 1;
  localparam int          N_RAND = 1500;

  typedef struct {
    logic [OW-1:0] data;
    int            lat;
    int            acc;
  } exp_t;

  logic aclk;
  logic aresetn;
  int   cyc;
  int   checks;
  int   errors;
  bit   rand_bp;
  bit   busy;
  exp_t sb[$];
  exp_t cur;

  tfix2float_if #(.W(W))  s_if ();
  tfix2float_if #(.W(OW)) m_if ();

  tfix2float #(.EXP(EXP), .FRA(FRA), .INT(INT), .DEC(DEC)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_axis  (s_if.slave),
    .m_axis  (m_if.master)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: value = x/2^DEC, normalised and rounded with integer arithmetic.
  function automatic logic [OW-1:0] ref_float(input logic [W-1:0] x, output int lz);
    int  v;
    int  e;
    int  q;
    int  sh;
    int  r;
    int  be;
    logic [EXP-1:0] ef;
    logic [FRA-1:0] ff;
    logic s;
    s  = x[W-1];
    v  = s ? (2 ** W) - int'(x) : int'(x);
    lz = W;
    if (v == 0) return '0;
    e = 0;
    for (int i = 0; i < int'(W); i++) if (((v >> i) & 1) == 1) e = i;
    lz = int'(W) - 1 - e;
    if (e > int'(FRA)) begin
      sh = e - int'(FRA);
      q  = v >> sh;
      r  = v - (q << sh);
      if (r > (1 << (sh - 1)) || (r == (1 << (sh - 1)) && (q % 2) == 1)) q++;
    end else begin
      q = v << (int'(FRA) - e);
    end
    if (q == 2 ** (FRA + 1)) begin
      q = 2 ** FRA;
      e++;
    end
    be = e - int'(DEC) + BIAS;
    if (be >= 2 ** EXP - 1) return {s, {EXP{1'b1}}, {FRA{1'b0}}};
    ef = be[EXP-1:0];
    ff = q[FRA-1:0];
    return {s, ef, ff};
  endfunction

  // Present one input, wait for acceptance, record the expected result.
  task automatic send(input logic [W-1:0] x, input logic [OW-1:0] expv);
    int   n;
    int   lz;
    exp_t e;
    logic [OW-1:0] unused_v;
    @(negedge aclk);
    s_if.tdata  = x;
    s_if.tvalid = 1'b1;
    n = 0;
    while (!s_if.tready && n < 300) begin
      @(negedge aclk);
      n++;
    end
    if (!s_if.tready) begin
      chk("accept_timeout", 32'(n), 32'(0));
      s_if.tvalid = 1'b0;
      return;
    end
    unused_v = ref_float(x, lz);
    e.data = expv;
    e.lat  = (x == '0) ? 2 : lz + 4;
    e.acc  = cyc + 1;
    sb.push_back(e);
    @(posedge aclk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || m_if.tvalid) && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'(0));
  endtask

  // Monitor: pop on the first cycle a result is shown, then check it holds.
  initial begin
    busy = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        busy = 1'b0;
      end else if (m_if.tvalid) begin
        if (!busy) begin
          busy = 1'b1;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h, expected none", m_if.tdata);
          end else begin
            cur = sb.pop_front();
            chk("data", 32'(m_if.tdata), 32'(cur.data));
            chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
          end
        end else begin
          chk("hold_data", 32'(m_if.tdata), 32'(cur.data));
        end
      end else begin
        busy = 1'b0;
      end
    end
  end

  // Random downstream stalls during the regression phase.
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      if (rand_bp) m_if.tready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]  dir_in  [9];
    logic [OW-1:0] dir_out [9];
    logic [W-1:0]  x;
    logic [OW-1:0] v;
    int            lz;

    dir_in  = '{16'h0100, 16'hFD80, 16'h0000, 16'h8000, 16'h0001,
                16'h7FFF, 16'h1002, 16'h1006, 16'h1003};
    dir_out = '{16'h3C00, 16'hC100, 16'h0000, 16'hD800, 16'h1C00,
                16'h5800, 16'h4C00, 16'h4C02, 16'h4C01};

    checks = 0;
    errors = 0;
    cyc = 0;
    rand_bp = 1'b0;
    aresetn = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    m_if.tready = 1'b1;

    #1;
    chk("rst_s_ready", 32'(s_if.tready), 32'(0));
    chk("rst_m_valid", 32'(m_if.tvalid), 32'(0));
    chk("rst_m_data", 32'(m_if.tdata), 32'(0));
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("idle_s_ready", 32'(s_if.tready), 32'(1));

    // Directed vectors, including rounding ties and exponent carry.
    for (int i = 0; i < 9; i++) send(dir_in[i], dir_out[i]);
    drain();

    // Backpressure: a pending result holds while a new input waits.
    m_if.tready = 1'b0;
    send(16'h0100, 16'h3C00);
    fork
      send(16'h0200, 16'h4000);
      begin
        repeat (12) @(negedge aclk);
        repeat (20) begin
          @(negedge aclk);
          chk("bp_s_ready", 32'(s_if.tready), 32'(0));
          chk("bp_m_valid", 32'(m_if.tvalid), 32'(1));
        end
        #1;
        m_if.tready = 1'b1;
      end
    join
    drain();

    // Reset during normalisation aborts the conversion.
    send(16'h0001, 16'h1C00);
    repeat (5) @(negedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    chk("abort_norm_m_valid", 32'(m_if.tvalid), 32'(0));
    chk("abort_norm_s_ready", 32'(s_if.tready), 32'(0));
    sb.delete();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    send(16'h0100, 16'h3C00);
    drain();

    // Reset while a result is being held clears it asynchronously.
    m_if.tready = 1'b0;
    send(16'h0100, 16'h3C00);
    repeat (15) @(negedge aclk);
    chk("pre_abort_m_valid", 32'(m_if.tvalid), 32'(1));
    #2;
    aresetn = 1'b0;
    #1;
    chk("abort_out_m_valid", 32'(m_if.tvalid), 32'(0));
    chk("abort_out_m_data", 32'(m_if.tdata), 32'(0));
    chk("abort_out_s_ready", 32'(s_if.tready), 32'(0));
    sb.delete();
    m_if.tready = 1'b1;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    send(16'h0100, 16'h3C00);
    drain();

    // Randomized regression spread across all leading-zero counts.
    rand_bp = 1'b1;
    for (int i = 0; i < N_RAND; i++) begin
      x = W'($urandom) >> $urandom_range(0, W - 1);
      if ($urandom_range(0, 1) == 1) x = ~x + W'(1);
      v = ref_float(x, lz);
      send(x, v);
    end
    rand_bp = 1'b0;
    m_if.tready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
